// File: rtl/arb_pkg.sv
// Shared constants, state type and helpers for the 4-way round-robin arbiter.
// The optional hold limit is enabled by defining ARB_HOLD_LIMIT_EN.
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int PTR_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector; zero when the vector is empty.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Stateless; the arbiter owns the pointer. No macro dependencies.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             found
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] rot_pick;

    // Rotate so that requester ptr lands at bit 0, isolate the lowest set bit,
    // then rotate the result back into requester numbering.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign rot[gi] = req[PTR_W'(gi) + ptr];
    end

    assign rot_pick = rot & (~rot + N_REQ'(1));

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unrot
        assign pick[gi] = rot_pick[PTR_W'(gi) - ptr];
    end

    assign found = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Define ARB_HOLD_LIMIT_EN to cap each grant at MAX_HOLD consecutive cycles.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       en,
    output logic [3:0] grant,
    output logic       grant_vld
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 1..255");
    end

    arb_state_t       state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic             vld_reg;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [N_REQ-1:0] pick;
    logic             found;
    logic             keep;
    logic             expire;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .pick  (pick),
        .found (found)
    );

    assign keep = |(req & grant_reg);

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_reg, hold_next;
    assign expire = (hold_reg == HOLD_W'(MAX_HOLD - 1));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
`ifdef ARB_HOLD_LIMIT_EN
        hold_next  = hold_reg;
`endif
        if (state_reg == IDLE) begin
            if (en && found) begin
                state_next = GRANTED;
                grant_next = pick;
                ptr_next   = onehot_to_idx(pick) + PTR_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
                hold_next  = '0;
`endif
            end
        end else if (keep && !expire) begin
`ifdef ARB_HOLD_LIMIT_EN
            hold_next = hold_reg + HOLD_W'(1);
`endif
        end else if (en && found) begin
            // Release or hold expiry: hand over on the same edge. On expiry the
            // current winner is still requesting, so it is re-picked last.
            state_next = GRANTED;
            grant_next = pick;
            ptr_next   = onehot_to_idx(pick) + PTR_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
            hold_next  = '0;
`endif
        end else if (keep) begin
            // Expired while enable is low: no new grant allowed, so the winner
            // keeps the grant and starts a fresh hold window.
`ifdef ARB_HOLD_LIMIT_EN
            hold_next = '0;
`endif
        end else begin
            state_next = IDLE;
            grant_next = '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_next  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            vld_reg   <= 1'b0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            vld_reg   <= |grant_next;
            ptr_reg   <= ptr_next;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_reg <= '0;
        else        hold_reg <= hold_next;
    end
`endif

    assign grant     = grant_reg;
    assign grant_vld = vld_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Randomised and directed bench for rr_arbiter_4 with a queue-based scoreboard.
// Build with ARB_HOLD_LIMIT_EN defined to exercise the hold limit (MAX_HOLD=3).
module tb_rr_arbiter_4;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int  MAX_HOLD = 3;
    localparam bit  HOLD_ON  = 1'b1;
`else
    localparam int  MAX_HOLD = 8;
    localparam bit  HOLD_ON  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       en = 1'b0;
    logic [3:0] grant;
    logic       grant_vld;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (en),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    string      name_q[$];

    // Reference model: owner index (-1 = nobody), rotating pointer, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic check(input string nm, input logic [3:0] g, input logic v,
                         input logic [3:0] eg);
        logic ev;
        ev = (eg != 4'b0000);
        checks++;
        if (g !== eg || v !== ev) begin
            errors++;
            $display("FAIL %s: got grant=%b vld=%b, expected grant=%b vld=%b", nm, g, v, eg, ev);
        end else begin
            $display("ok   %s: grant=%b vld=%b", nm, g, v);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic grant_new(input logic [3:0] r);
        m_owner = first_from(r, m_ptr);
        m_ptr   = (m_owner + 1) % 4;
        m_cnt   = 0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    function automatic logic [3:0] model_grant();
        logic [3:0] one;
        one = 4'b0001;
        return (m_owner < 0) ? 4'b0000 : (one << m_owner);
    endfunction

    task automatic model_step(input logic [3:0] r, input logic e);
        if (m_owner < 0) begin
            if (e && r != 4'b0000) grant_new(r);
        end else if (r[m_owner]) begin
            if (HOLD_ON && m_cnt == MAX_HOLD - 1) begin
                if (e) grant_new(r);
                else   m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (e && r != 4'b0000) begin
            grant_new(r);
        end else begin
            m_owner = -1;
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what the next
    // rising edge must produce.
    task automatic step(input string nm, input logic [3:0] r, input logic e,
                        input logic rst = 1'b1);
        @(negedge clk);
        req   = r;
        en    = e;
        rst_n = rst;
        if (!rst) model_reset();
        else      model_step(r, e);
        exp_q.push_back(model_grant());
        name_q.push_back(nm);
    endtask

    // Monitor: compares each queued expectation just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), grant, grant_vld, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("reset_hold", grant, grant_vld, 4'b0000);
        step("reset_cycle", 4'b0100, 1'b1, 1'b0);
        step("reset_cycle", 4'b0100, 1'b1, 1'b0);

        // Single request, then hold while it stays high.
        for (int i = 0; i < 4; i++) step("single_req", 4'b0100, 1'b1);
        step("release", 4'b0000, 1'b1);

        // Rotation: everyone requesting, winner drops for one cycle after grant.
        for (int i = 0; i < 5; i++) begin
            step("rotate_req", 4'b1111, 1'b1);
            step("rotate_drop", 4'b1111 & ~model_grant(), 1'b1);
        end
        step("release", 4'b0000, 1'b1);

        // Zero-bubble handover.
        for (int i = 0; i < 2; i++) step("handover_a", 4'b0011, 1'b1);
        step("handover_b", 4'b0010, 1'b1);
        step("release", 4'b0000, 1'b1);

        // Enable gating.
        for (int i = 0; i < 3; i++) step("en_low_idle", 4'b1010, 1'b0);
        step("en_grant3", 4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) step("en_low_keep", 4'b1000, 1'b0);
        step("en_low_drop", 4'b0000, 1'b0);

        // Hold-limit patterns (plain holding when the limit is not built).
        for (int i = 0; i < 10; i++) step("hold_two", 4'b0011, 1'b1);
        for (int i = 0; i < 6; i++) step("hold_solo", 4'b0001, 1'b1);
        step("release", 4'b0000, 1'b1);

        // Asynchronous reset between edges while a grant is held.
        for (int i = 0; i < 2; i++) step("pre_async", 4'b0100, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", grant, grant_vld, 4'b0000);
        model_reset();
        step("in_reset", 4'b1111, 1'b1, 1'b0);
        step("post_reset", 4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("post_reset", 4'b1111, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("random", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        step("release", 4'b0000, 1'b1);

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0 pending", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter producing a registered one-hot grant vector. Sits directly upstream of the 4-to-2 encoder stage: `grant` drives the encoder input, and `grant_vld` qualifies the encoded index. Holds a grant while the winner keeps requesting and rotates priority so that no requester starves.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per winner; legal range 1..255. Used only when `ARB_HOLD_LIMIT_EN` is defined.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req` input, 4 bits: request lines; bit i is requester i.
- `en` input, 1 bit: arbitration enable; when low, no new grant is issued.
- `grant` output, 4 bits: registered grant, one-hot or all-zero, never multi-hot.
- `grant_vld` output, 1 bit: high exactly when `grant` is non-zero.

## Operation
- FSM states:
  - `IDLE`: `grant` is 0.
  - `GRANTED`: exactly one `grant` bit set; current winner is g.
- Priority pointer `ptr` (2 bits): search starts at `ptr` and wraps 3→0. After each new grant to g, `ptr = g+1` mod 4.
- `IDLE` transitions:
  - `en`=1 and `req`≠0: grant the first set `req` bit at or after `ptr`; go to `GRANTED`.
  - Otherwise stay in `IDLE`.
- `GRANTED` transitions:
  - `req[g]`=1 and no hold expiry: keep g; `en` is ignored.
  - `req[g]`=0: release g.
    - If `en`=1 and another request is pending, grant the next winner from `ptr` on the same edge (zero-bubble handover); stay in `GRANTED`.
    - Otherwise go to `IDLE`.
- `en` falling while in `GRANTED` does not revoke the current grant. It only blocks the next new grant.
- Requests from non-winners are never latched; a request must be high at the decision edge to count.
- Reset value of every output: `grant`=4'b0000, `grant_vld`=0. Internal reset values: `ptr`=0, hold counter=0, state `IDLE`.
- Reset asserted mid-grant clears everything immediately, without waiting for a clock. First arbitration after reset starts at requester 0.

## Timing
- Request-to-grant latency in `IDLE`: 1 cycle. `req` sampled high at edge k gives `grant` high after edge k.
- Release latency: `grant[g]` clears on the first edge where `req[g]` is sampled low.
- Handover: the old grant clears and the new grant sets on the same edge; there is no cycle with two bits set.
- `grant_vld` is registered together with `grant` and has identical timing.
- Simultaneous requests: resolved strictly by rotating order from `ptr`, never by fixed index.

## Configuration
- Macro `ARB_HOLD_LIMIT_EN`.
- Defined:
  - A hold counter counts cycles in the current grant and resets to 0 on every new grant.
  - When the counter reaches `MAX_HOLD`−1 and `req[g]` is still high, the next edge re-arbitrates from `ptr` (= g+1). Any other pending requester wins.
  - If g is the only requester, g is re-granted and the counter restarts at 0.
- Not defined:
  - No counter is built.
  - A winner holds the grant indefinitely while `req[g]` stays high.
  - `MAX_HOLD` is ignored.

## Structure
- Package `arb_pkg` contains:
  - `N_REQ` = 4.
  - `PTR_W` = 2.
  - `HOLD_W` = 8.
  - State enum `arb_state_t {IDLE, GRANTED}`.
- Sub-module `rr_pick`: combinational picker. Inputs `req` and `ptr`; outputs a one-hot pick and a found flag. It contains no state. The FSM, pointer, counter and output registers stay in `rr_arbiter_4`.

## Test plan
- Reset and single request: hold `rst_n` low; `grant`=0000 and `grant_vld`=0. Release reset, then `req`=0100 with `en`=1 → `grant`=0100 one cycle later, held while `req[2]` stays high.
- Rotation: `req`=1111 held constant with `en`=1, each winner dropping its request for one cycle after being granted → grants in order 0001, 0010, 0100, 1000, 0001.
- Zero-bubble handover: winner 0 with `req`=0011, then `req[0]` drops → `grant` goes 0001→0010 on the same edge; `grant_vld` stays 1 throughout.
- Enable gating: with `en`=0 and `req`=1010 → `grant` stays 0000. With `en` lowered while grant=1000 is held → grant is kept until `req[3]` drops, then `grant`=0000.
- Hold limit (with `ARB_HOLD_LIMIT_EN`, `MAX_HOLD`=3): `req`=0011 constant → 0001 for 3 cycles, 0010 for 3 cycles, then 0001 again. With `req`=0001 only → 0001 is continuously re-granted.
- Asynchronous reset mid-grant: assert `rst_n`=0 between clock edges while grant=0100 → `grant`=0000 immediately. After release with `req`=1111 → first grant is 0001.
